// File: rtl/load_store_unit.sv
// Data-memory access sequencer: latches one load/store, issues a single strobe,
// waits MEM_LATENCY cycles for read data and returns it as a register-file write.
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        clk_en,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [2:0]  req_rd,
  output logic        stall,
  output logic        wb_en,
  output logic [2:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        lsu_err,
  output logic [31:0] data_memory_a,
  output logic [31:0] data_memory_out_v,
  output logic [1:0]  data_memory_s,
  output logic        data_memory_read,
  output logic        data_memory_write,
  input  logic [31:0] data_memory_in_v
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [2:0]          rd_q, rd_d;
  logic                store_q, store_d;
  logic                rd_strobe_q, rd_strobe_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic                wb_en_q, wb_en_d;
  logic [2:0]          wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                err_q, err_d;
  logic                req_bad;
  logic [DATA_W-1:0]   req_wdata_masked;
  logic [DATA_W-1:0]   ext_data;
  logic                bus_on;

  // Request legality and store-data masking
  always_comb begin
    req_bad = (req_size == 2'b11) ||
              ((req_size == 2'b01) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    unique case (req_size)
      2'b00:   req_wdata_masked = {24'd0, req_wdata[7:0]};
      2'b01:   req_wdata_masked = {16'd0, req_wdata[15:0]};
      default: req_wdata_masked = req_wdata;
    endcase
  end

  // Load-data extension from the latched size/signedness
  always_comb begin
    unique case (size_q)
      2'b00:   ext_data = {{24{signed_q & data_memory_in_v[7]}}, data_memory_in_v[7:0]};
      2'b01:   ext_data = {{16{signed_q & data_memory_in_v[15]}}, data_memory_in_v[15:0]};
      default: ext_data = data_memory_in_v;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    signed_d    = signed_q;
    rd_d        = rd_q;
    store_d     = store_q;
    rd_strobe_d = 1'b0;
    wr_strobe_d = 1'b0;
    wb_en_d     = 1'b0;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            addr_d      = req_addr;
            wdata_d     = req_wdata_masked;
            size_d      = req_size;
            signed_d    = req_signed;
            rd_d        = req_rd;
            store_d     = req_store;
            rd_strobe_d = ~req_store;
            wr_strobe_d = req_store;
            state_d     = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (store_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          wb_en_d   = 1'b1;
          wb_reg_d  = rd_q;
          wb_data_d = ext_data;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      rd_q        <= '0;
      store_q     <= 1'b0;
      rd_strobe_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      rd_q        <= rd_d;
      store_q     <= store_d;
      rd_strobe_q <= rd_strobe_d;
      wr_strobe_q <= wr_strobe_d;
      wb_en_q     <= wb_en_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  // A held ACCESS cycle with clk_en low shows an idle bus and is re-issued later
  assign bus_on            = (rd_strobe_q | wr_strobe_q) & clk_en;
  assign data_memory_read  = rd_strobe_q & clk_en;
  assign data_memory_write = wr_strobe_q & clk_en;
  assign data_memory_a     = bus_on ? addr_q  : '0;
  assign data_memory_out_v = bus_on ? wdata_q : '0;
  assign data_memory_s     = bus_on ? size_q  : '0;

  assign stall   = (state_q == S_ACCESS) || (state_q == S_WAIT) || (state_q == S_ERR) ||
                   ((state_q == S_IDLE) && req_valid);
  assign wb_en   = wb_en_q;
  assign wb_reg  = wb_reg_q;
  assign wb_data = wb_data_q;
  assign lsu_err = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver queues expected strobes and
// write-backs, a negedge monitor pops and compares them, a memory model answers reads.
module tb_load_store_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        clk_en = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [2:0]  req_rd = '0;
  logic        stall, wb_en, lsu_err;
  logic [2:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] data_memory_a, data_memory_out_v;
  logic [1:0]  data_memory_s;
  logic        data_memory_read, data_memory_write;
  logic [31:0] data_memory_in_v = '0;

  load_store_unit #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .nreset(nreset), .clk_en(clk_en),
    .req_valid(req_valid), .req_store(req_store), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
    .req_rd(req_rd), .stall(stall), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .lsu_err(lsu_err), .data_memory_a(data_memory_a),
    .data_memory_out_v(data_memory_out_v), .data_memory_s(data_memory_s),
    .data_memory_read(data_memory_read), .data_memory_write(data_memory_write),
    .data_memory_in_v(data_memory_in_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        is_wr;
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] ov;
  } strobe_t;

  typedef struct {
    int          cyc;
    logic [2:0]  r;
    logic [31:0] d;
  } wb_t;

  strobe_t     sb_s[$];
  wb_t         sb_w[$];
  int          cyc = 0;
  int          done_cyc = -1;
  logic        exp_err = 1'b0;
  logic [31:0] mem_rdata = '0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] d, input logic [1:0] sz,
                                            input logic sg);
    longint v;
    if (sz == 2'd0) begin
      v = longint'(d % 256);
      if (sg && v >= 128) v -= 256;
    end else if (sz == 2'd1) begin
      v = longint'(d % 65536);
      if (sg && v >= 32768) v -= 65536;
    end else begin
      v = longint'(d);
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] mask_model(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return d % 256;
    if (sz == 2'd1) return d % 65536;
    return d;
  endfunction

  // Memory: garbage until LAT edges after the read strobe, then the requested word
  initial begin : memory
    logic armed;
    int   rem;
    armed = 1'b0;
    rem = 0;
    forever begin
      @(negedge clk);
      if (!nreset) armed = 1'b0;
      else if (data_memory_read && !armed) begin
        armed = 1'b1;
        rem = LAT;
        data_memory_in_v = $urandom;
      end
      @(posedge clk);
      if (armed && nreset) begin
        rem--;
        if (rem == 0) begin
          #1;
          data_memory_in_v = mem_rdata;
          armed = 1'b0;
        end
      end
    end
  end

  // Monitor
  initial begin : monitor
    strobe_t es;
    wb_t     ew;
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (data_memory_read || data_memory_write) begin
          if (sb_s.size() == 0) begin
            chk("strobe_unexpected", {30'd0, data_memory_write, data_memory_read}, 32'd0);
          end else begin
            es = sb_s.pop_front();
            chk("strobe_cycle", 32'(cyc), 32'(es.cyc));
            chk("strobe_kind", {30'd0, data_memory_write, data_memory_read},
                {30'd0, es.is_wr, ~es.is_wr});
            chk("strobe_addr", data_memory_a, es.a);
            chk("strobe_size", 32'(data_memory_s), 32'(es.s));
            chk("strobe_wdata", data_memory_out_v, es.ov);
          end
        end else begin
          chk("bus_idle_zero", data_memory_a | data_memory_out_v | 32'(data_memory_s), 32'd0);
        end
        if (wb_en) begin
          if (sb_w.size() == 0) begin
            chk("wb_unexpected", 32'(wb_en), 32'd0);
          end else begin
            ew = sb_w.pop_front();
            chk("wb_cycle", 32'(cyc), 32'(ew.cyc));
            chk("wb_reg", 32'(wb_reg), 32'(ew.r));
            chk("wb_data", wb_data, ew.d);
          end
        end
        chk("stall", 32'(stall), 32'(exp_err | (req_valid && cyc != done_cyc)));
        chk("lsu_err", 32'(lsu_err), 32'(exp_err));
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_reg", 32'(wb_reg), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_lsu_err", 32'(lsu_err), 32'd0);
    chk("rst_mem_a", data_memory_a, 32'd0);
    chk("rst_mem_out_v", data_memory_out_v, 32'd0);
    chk("rst_mem_s", 32'(data_memory_s), 32'd0);
    chk("rst_mem_read", 32'(data_memory_read), 32'd0);
    chk("rst_mem_write", 32'(data_memory_write), 32'd0);
  endtask

  // Called just after a rising edge; asserts reset asynchronously mid-cycle
  task automatic do_reset();
    req_valid = 1'b0;
    clk_en = 1'b1;
    nreset = 1'b0;
    #1;
    chk_reset_outputs();
    sb_s.delete();
    sb_w.delete();
    exp_err = 1'b0;
    done_cyc = -1;
    @(posedge clk);
    @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  // Presents one request just after a rising edge and returns after it retires
  task automatic issue(input logic st, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sg, input logic [2:0] rd,
                       input logic [31:0] rdat, input int gap);
    int      k;
    logic    bad;
    strobe_t es;
    wb_t     ew;
    k = cyc;
    bad = (sz == 2'd3) || ((ad % (32'd1 << sz)) != 0);
    req_store = st; req_addr = ad; req_wdata = wd; req_size = sz;
    req_signed = sg; req_rd = rd; mem_rdata = rdat;
    req_valid = 1'b1;
    if (bad) begin
      @(posedge clk);
      #1;
      exp_err = 1'b1;
      req_valid = 1'b0;
      repeat (22) @(posedge clk);
      #1;
      do_reset();
      return;
    end
    es.cyc = k + 1; es.is_wr = st; es.a = ad; es.s = sz; es.ov = mask_model(wd, sz);
    sb_s.push_back(es);
    if (st) begin
      done_cyc = k + 2;
    end else begin
      done_cyc = k + 2 + LAT + gap;
      ew.cyc = done_cyc; ew.r = rd; ew.d = ext_model(rdat, sz, sg);
      sb_w.push_back(ew);
    end
    @(posedge clk);
    #1;
    if (gap > 0 && !st) begin
      @(posedge clk);
      #1;
      clk_en = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
      clk_en = 1'b1;
    end
    while (cyc < done_cyc + 1) begin
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  // Load cut short by reset while waiting for memory data
  task automatic issue_abort(input logic [31:0] ad);
    strobe_t es;
    req_store = 1'b0; req_addr = ad; req_size = 2'd2; req_signed = 1'b0; req_rd = 3'd5;
    mem_rdata = 32'h1234_5678;
    req_valid = 1'b1;
    es.cyc = cyc + 1; es.is_wr = 1'b0; es.a = ad; es.s = 2'd2; es.ov = 32'd0;
    sb_s.push_back(es);
    done_cyc = cyc + 2 + LAT;
    @(posedge clk);
    @(posedge clk);
    #1;
    do_reset();
  endtask

  initial begin : driver
    logic        st, sg;
    logic [1:0]  sz;
    logic [31:0] ad;
    int          gap;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 3'd3, 32'h8000_00F0, 0);
    issue(1'b0, 32'h7, 32'h0, 2'd0, 1'b1, 3'd1, 32'h0000_0085, 0);
    issue(1'b0, 32'h7, 32'h0, 2'd0, 1'b0, 3'd2, 32'h0000_0085, 0);
    issue(1'b0, 32'h22, 32'h0, 2'd1, 1'b1, 3'd4, 32'h0000_9ABC, 0);
    issue(1'b1, 32'h22, 32'hDEAD_BEEF, 2'd1, 1'b0, 3'd0, 32'h0, 0);
    issue(1'b1, 32'h13, 32'hCAFE_F00D, 2'd0, 1'b0, 3'd0, 32'h0, 0);
    issue(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 3'd6, 32'hA5A5_0F0F, 2);
    issue(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 3'd1, 32'h0, 0);
    issue(1'b0, 32'h200, 32'h0, 2'd3, 1'b0, 3'd1, 32'h0, 0);
    issue_abort(32'h300);
    issue(1'b0, 32'h304, 32'h0, 2'd2, 1'b0, 3'd7, 32'h0BAD_CAFE, 0);
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 7) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      gap = (!st && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      issue(st, ad, $urandom, sz, sg, 3'($urandom_range(0, 7)), $urandom, gap);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("strobes_outstanding", 32'(sb_s.size()), 32'd0);
    chk("wb_outstanding", 32'(sb_w.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
